// File: rtl/or_reduce_accum.sv
// Masked bit-wise OR of CHANNELS words, OR-accumulated over a frame of FRAME_LEN beats (or until flush).
// Latency: out_valid rises on the edge that accepts the closing beat.
// Backpressure: in_ready drops while a result is held, until out_valid && out_ready. Optional hit_chan port: `define OR_REDUCE_HIT_EN.
module or_reduce_accum #(
  parameter int WIDTH     = 4,
  parameter int CHANNELS  = 8,
  parameter int FRAME_LEN = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS-1:0]       chan_mask,
  input  logic                      flush,
  output logic [WIDTH-1:0]          out_data,
  output logic [7:0]                out_beats,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef OR_REDUCE_HIT_EN
  ,
  output logic [CHANNELS-1:0]       hit_chan
`endif
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     cnt_inc;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [7:0]        out_beats_q, out_beats_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  red;
  logic              accept;
  logic              close;

`ifdef OR_REDUCE_HIT_EN
  logic [CHANNELS-1:0] hit_red;
  logic [CHANNELS-1:0] hit_acc_q, hit_acc_d;
  logic [CHANNELS-1:0] hit_out_q, hit_out_d;
`endif

  // Ready depends only on registered state, so no path from out_ready.
  assign in_ready = (state_q != HOLD);
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = cnt_q + CW'(1);

  // A frame closes when the last beat lands or when flush arrives with at least one beat in the frame.
  assign close = (state_q != HOLD) &&
                 ((accept && (cnt_inc == LAST)) || (flush && (accept || (cnt_q != '0))));

  // Masked per-bit OR across all channels of the current beat.
  always_comb begin
    red = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      red = red | (in_data[c*WIDTH +: WIDTH] & {WIDTH{chan_mask[c]}});
    end
  end

`ifdef OR_REDUCE_HIT_EN
  // Per-channel "any bit set" flags for masked-in channels of the current beat.
  always_comb begin
    hit_red = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      hit_red[c] = chan_mask[c] & (|in_data[c*WIDTH +: WIDTH]);
    end
  end
`endif

  // Next-state and datapath updates; everything holds unless a case below changes it.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_beats_d = out_beats_q;
    out_valid_d = out_valid_q;
`ifdef OR_REDUCE_HIT_EN
    hit_acc_d   = hit_acc_q;
    hit_out_d   = hit_out_q;
`endif
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d   = acc_q | red;
          cnt_d   = cnt_inc;
          state_d = ACCUM;
`ifdef OR_REDUCE_HIT_EN
          hit_acc_d = hit_acc_q | hit_red;
`endif
        end
        if (close) begin
          // acc_d/cnt_d already include a same-cycle beat.
          state_d     = HOLD;
          out_data_d  = acc_d;
          out_beats_d = 8'(cnt_d);
          out_valid_d = 1'b1;
`ifdef OR_REDUCE_HIT_EN
          hit_out_d   = hit_acc_d;
`endif
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = IDLE;
          acc_d       = '0;
          cnt_d       = '0;
          out_valid_d = 1'b0;
`ifdef OR_REDUCE_HIT_EN
          hit_acc_d   = '0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any partial or held frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_beats_q <= '0;
      out_valid_q <= 1'b0;
`ifdef OR_REDUCE_HIT_EN
      hit_acc_q   <= '0;
      hit_out_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_beats_q <= out_beats_d;
      out_valid_q <= out_valid_d;
`ifdef OR_REDUCE_HIT_EN
      hit_acc_q   <= hit_acc_d;
      hit_out_q   <= hit_out_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_beats = out_beats_q;
  assign out_valid = out_valid_q;
`ifdef OR_REDUCE_HIT_EN
  assign hit_chan  = hit_out_q;
`endif

endmodule

// File: tb/tb_or_reduce_accum.sv
// Randomized and directed bench for or_reduce_accum with a frame-level reference model and scoreboard.
// Frame length 4 by default; 1 when OR_REDUCE_HIT_EN is defined, exercising the hit_chan port.
// The driver predicts each frame result into a queue; a negedge monitor checks it while it is held.
module tb_or_reduce_accum;

  localparam int WIDTH    = 4;
  localparam int CHANNELS = 8;
`ifdef OR_REDUCE_HIT_EN
  localparam int FRAME_LEN = 1;
`else
  localparam int FRAME_LEN = 4;
`endif
  localparam int DW = WIDTH * CHANNELS;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [DW-1:0]       in_data = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [CHANNELS-1:0] chan_mask = '0;
  logic                flush = 1'b0;
  logic [WIDTH-1:0]    out_data;
  logic [7:0]          out_beats;
  logic                out_valid;
  logic                out_ready = 1'b0;
`ifdef OR_REDUCE_HIT_EN
  logic [CHANNELS-1:0] hit_chan;
`endif

  or_reduce_accum #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .chan_mask(chan_mask), .flush(flush),
    .out_data(out_data), .out_beats(out_beats),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef OR_REDUCE_HIT_EN
    , .hit_chan(hit_chan)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0]    d;
    logic [7:0]          b;
    logic [CHANNELS-1:0] h;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic exp_in_ready = 1'b1;
  logic exp_out_valid = 1'b0;
  logic chk_en = 1'b0;

  // Reference model: frame contents so far and whether a result is being held.
  bit                  m_hold = 1'b0;
  int                  m_n = 0;
  logic [WIDTH-1:0]    m_or = '0;
  logic [CHANNELS-1:0] m_hit = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] chw(input int c, input logic [WIDTH-1:0] v);
    logic [DW-1:0] r;
    r = '0;
    r[c*WIDTH +: WIDTH] = v;
    return r;
  endfunction

  // Drive one cycle of inputs and advance the model to what the next edge should produce.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic [CHANNELS-1:0] m,
                      input logic f, input logic r);
    logic [WIDTH-1:0] w;
    @(posedge clk);
    #1;
    exp_in_ready  = !m_hold;
    exp_out_valid = m_hold;
    chk_en        = 1'b1;
    in_valid  = v;
    in_data   = d;
    chan_mask = m;
    flush     = f;
    out_ready = r;
    if (m_hold) begin
      if (r) m_hold = 1'b0;
    end else begin
      if (v) begin
        for (int c = 0; c < CHANNELS; c++) begin
          w = d[c*WIDTH +: WIDTH];
          if (m[c]) begin
            m_or = m_or | w;
            if (w != '0) m_hit[c] = 1'b1;
          end
        end
        m_n++;
      end
      if (m_n == FRAME_LEN || (f && m_n > 0)) begin
        exp_q.push_back('{d: m_or, b: 8'(m_n), h: m_hit});
        m_hold = 1'b1;
        m_n    = 0;
        m_or   = '0;
        m_hit  = '0;
      end
    end
  endtask

  // Assert reset between clock edges and check outputs clear without waiting for a clock.
  task automatic reset_mid();
    @(posedge clk);
    #3;
    in_valid = 1'b0;
    flush    = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_beats", 32'(out_beats), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
`ifdef OR_REDUCE_HIT_EN
    check("rst_hit_chan",  32'(hit_chan),  32'd0);
`endif
    m_hold = 1'b0;
    m_n    = 0;
    m_or   = '0;
    m_hit  = '0;
    exp_q.delete();
    exp_in_ready  = 1'b1;
    exp_out_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: checks ready/valid every cycle and the held result against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("in_ready",  32'(in_ready),  32'(exp_in_ready));
      check("out_valid", 32'(out_valid), 32'(exp_out_valid));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_result: out_data=%0h out_beats=%0d with nothing expected at %0t",
                   out_data, out_beats, $time);
        end else begin
          check("out_data",  32'(out_data),  32'(exp_q[0].d));
          check("out_beats", 32'(out_beats), 32'(exp_q[0].b));
`ifdef OR_REDUCE_HIT_EN
          check("hit_chan",  32'(hit_chan),  32'(exp_q[0].h));
`endif
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    // Reset state while rst_n is held low.
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data",  32'(out_data),  32'd0);
    check("reset_out_beats", 32'(out_beats), 32'd0);
    check("reset_in_ready",  32'(in_ready),  32'd1);
    #11;
    rst_n = 1'b1;

    // Frame of 4 beats with all channels enabled, result held for two cycles before handshake.
    step(1, chw(0, 4'h1), 8'hFF, 0, 0);
    step(1, chw(3, 4'h2), 8'hFF, 0, 0);
    step(1, chw(7, 4'h4), 8'hFF, 0, 0);
    step(1, '0,           8'hFF, 0, 0);
    step(0, '0, 8'hFF, 0, 0);
    step(0, '0, 8'hFF, 0, 0);
    step(0, '0, 8'hFF, 0, 1);

    // Only channel 0 enabled; all the set bits sit in masked-off channels.
    for (int i = 0; i < 5; i++) step(1, 32'hFFFF_FFF0, 8'h01, 0, 1);
    step(0, '0, 8'h00, 0, 1);

    // Early close by flush on the second beat, then a flush in IDLE that must be ignored.
    step(1, chw(2, 4'h8), 8'hFF, 0, 1);
    step(1, chw(2, 4'h8), 8'hFF, 1, 1);
    step(0, '0, 8'hFF, 0, 1);
    step(0, '0, 8'hFF, 1, 1);
    step(0, '0, 8'hFF, 0, 1);

    // Long backpressure while the source keeps offering beats, then a fresh frame.
    for (int i = 0; i < 4; i++) step(1, chw(i, 4'h3), 8'hFF, 0, 0);
    for (int i = 0; i < 10; i++) step(1, chw(6, 4'hF), 8'hFF, 0, 0);
    step(1, chw(6, 4'hF), 8'hFF, 0, 1);
    for (int i = 0; i < 4; i++) step(1, chw(1, 4'h2), 8'hFF, 0, 1);
    step(0, '0, 8'hFF, 0, 1);

    // Reset partway through a frame, then a clean frame of 4'h1.
    for (int i = 0; i < 3; i++) step(1, chw(4, 4'h6), 8'hFF, 0, 0);
    reset_mid();
    for (int i = 0; i < 4; i++) step(1, chw(0, 4'h1), 8'hFF, 0, 1);
    step(0, '0, 8'hFF, 0, 1);

    // Single beat on channel 5.
    step(1, chw(5, 4'h3), 8'hFF, 0, 1);
    step(0, '0, 8'hFF, 0, 1);
    step(0, '0, 8'hFF, 0, 1);

    // Random traffic: sparse channel data, random masks, occasional flush and backpressure.
    for (int i = 0; i < 3000; i++) begin
      d = '0;
      for (int c = 0; c < CHANNELS; c++) begin
        if ($urandom_range(3) == 0) d[c*WIDTH +: WIDTH] = WIDTH'($urandom);
      end
      step(logic'($urandom_range(9) < 7), d, CHANNELS'($urandom),
           logic'($urandom_range(9) == 0), logic'($urandom_range(9) < 6));
      if (i == 1500) reset_mid();
    end

    // Drain the last result and confirm every prediction was consumed.
    for (int i = 0; i < 4; i++) step(0, '0, '0, 0, 1);
    @(negedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
